// File: rtl/auth_req_assembler.sv
// ---------------------------------------------------------------------------
// auth_req_assembler
//   Upstream stage of the authentication responder. Gathers a byte-serial
//   authentication request from the PD transport into a MSG_BITS-wide bus,
//   checks header, length and inter-byte timing, then offers each good
//   message to the responder with a held request/ack handshake. Bad
//   messages raise a one-cycle error pulse and are dropped.
//
// Ports
//   clk               in   rising-edge clock
//   reset             in   asynchronous reset, active low
//   byte_valid_in     in   transport byte valid
//   byte_data_in      in   transport byte
//   byte_last_in      in   final byte of message (qualified by valid)
//   byte_ready_out    out  assembler can accept a byte
//   resp_req_out      out  message available to responder
//   auth_msg_resp_out out  packed message, byte k at bits [8k+7:8k]
//   msg_len_out       out  byte count of presented message
//   resp_ack_in       in   responder consumed the message
//   err_out           out  one-cycle error pulse
//   err_code_out      out  01 timeout, 10 overflow, 11 format; held
// ---------------------------------------------------------------------------
module auth_req_assembler #(
  parameter int         MSG_BITS    = 1000,
  parameter int         TIMEOUT_CYC = 1024,
  parameter logic [7:0] PROTO_VER   = 8'h01,
  parameter int         MIN_BYTES   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                byte_valid_in,
  input  logic [7:0]          byte_data_in,
  input  logic                byte_last_in,
  output logic                byte_ready_out,
  output logic                resp_req_out,
  output logic [MSG_BITS-1:0] auth_msg_resp_out,
  output logic [6:0]          msg_len_out,
  input  logic                resp_ack_in,
  output logic                err_out,
  output logic [1:0]          err_code_out
);

  localparam int MSG_BYTES = MSG_BITS / 8;
  localparam int TO_W      = $clog2(TIMEOUT_CYC + 1);

  localparam logic [6:0]      MAX_CNT = 7'(MSG_BYTES);
  localparam logic [6:0]      MIN_CNT = 7'(MIN_BYTES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_FORMAT   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_PRESENT,
    S_DISCARD
  } state_e;

  state_e              state_q, state_d;
  logic [MSG_BITS-1:0] buf_q, buf_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [6:0]          len_q, len_d;
  logic [TO_W-1:0]     idle_q, idle_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;

  logic       accept;
  logic [6:0] cnt_inc;
  logic [9:0] wr_idx;

  function automatic logic hdr_pass(input logic [7:0] b0, input logic [6:0] n);
    return (b0 == PROTO_VER) && (n >= MIN_CNT);
  endfunction

  assign accept  = byte_valid_in & (state_q != S_PRESENT);
  assign cnt_inc = cnt_q + 7'd1;
  assign wr_idx  = {cnt_q, 3'b000};

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    idle_d  = idle_q;
    err_d   = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE: begin
        // The buffer is always clear on entry to IDLE.
        idle_d = '0;
        if (accept) begin
          if (byte_last_in) begin
            if (hdr_pass(byte_data_in, 7'd1)) begin
              buf_d[7:0] = byte_data_in;
              cnt_d      = 7'd1;
              len_d      = 7'd1;
              state_d    = S_PRESENT;
            end else begin
              err_d  = 1'b1;
              code_d = ERR_FORMAT;
            end
          end else begin
            buf_d[7:0] = byte_data_in;
            cnt_d      = 7'd1;
            state_d    = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (accept) begin
          // An accept always wins over a coincident timeout expiry.
          idle_d = '0;
          if (cnt_q == MAX_CNT) begin
            err_d   = 1'b1;
            code_d  = ERR_OVERFLOW;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = byte_last_in ? S_IDLE : S_DISCARD;
          end else if (byte_last_in && !hdr_pass(buf_q[7:0], cnt_inc)) begin
            err_d   = 1'b1;
            code_d  = ERR_FORMAT;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            buf_d[wr_idx +: 8] = byte_data_in;
            cnt_d              = cnt_inc;
            if (byte_last_in) begin
              len_d   = cnt_inc;
              state_d = S_PRESENT;
            end
          end
        end else if (idle_q == TO_LAST) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          buf_d   = '0;
          cnt_d   = '0;
          idle_d  = '0;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + TO_ONE;
        end
      end
      S_PRESENT: begin
        if (resp_ack_in) begin
          buf_d   = '0;
          cnt_d   = '0;
          len_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_DISCARD: begin
        // Remainder of an overflowed message; its error was already reported.
        if (accept) begin
          idle_d = '0;
          if (byte_last_in) state_d = S_IDLE;
        end else if (idle_q == TO_LAST) begin
          idle_d  = '0;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + TO_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      idle_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign byte_ready_out    = reset & (state_q != S_PRESENT);
  assign resp_req_out      = (state_q == S_PRESENT);
  assign auth_msg_resp_out = buf_q;
  assign msg_len_out       = len_q;
  assign err_out           = err_q;
  assign err_code_out      = code_q;

endmodule

// File: tb/tb_auth_req_assembler.sv
module tb_auth_req_assembler;

  localparam int MSG_BITS = 1000;
  localparam int TO_CYC   = 1024;

  logic                clk = 1'b0;
  logic                reset;
  logic                byte_valid_in;
  logic [7:0]          byte_data_in;
  logic                byte_last_in;
  logic                byte_ready_out;
  logic                resp_req_out;
  logic [MSG_BITS-1:0] auth_msg_resp_out;
  logic [6:0]          msg_len_out;
  logic                resp_ack_in;
  logic                err_out;
  logic [1:0]          err_code_out;

  auth_req_assembler dut (
    .clk               (clk),
    .reset             (reset),
    .byte_valid_in     (byte_valid_in),
    .byte_data_in      (byte_data_in),
    .byte_last_in      (byte_last_in),
    .byte_ready_out    (byte_ready_out),
    .resp_req_out      (resp_req_out),
    .auth_msg_resp_out (auth_msg_resp_out),
    .msg_len_out       (msg_len_out),
    .resp_ack_in       (resp_ack_in),
    .err_out           (err_out),
    .err_code_out      (err_code_out)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  int   err_cnt = 0;
  int   err_at = 0;
  int   req_rise = 0;
  int   bytes_acc = 0;
  logic req_prev = 1'b0;
  logic [7:0] msg_b [0:255];

  // Event monitor: counts error-pulse cycles and request rising edges.
  always @(negedge clk) begin
    if (err_out === 1'b1) begin
      err_cnt++;
      err_at = bytes_acc;
    end
    if (resp_req_out === 1'b1 && req_prev !== 1'b1) req_rise++;
    req_prev = resp_req_out;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until the DUT takes it (ready is stable between edges).
  task automatic drive_byte(input logic [7:0] d, input logic last);
    logic rdy;
    int   waited;
    waited = 0;
    byte_valid_in = 1'b1;
    byte_data_in  = d;
    byte_last_in  = last;
    do begin
      rdy = byte_ready_out;
      @(posedge clk);
      #1;
      waited++;
    end while (!rdy && waited < 50);
    byte_valid_in = 1'b0;
    byte_last_in  = 1'b0;
    if (rdy) bytes_acc++;
    else begin
      n_chk++;
      n_fail++;
      $error("FAIL accept_bound: observed no accept in 50 cycles, required accept");
    end
  endtask

  task automatic send_msg(input int n, input int maxgap);
    bytes_acc = 0;
    for (int i = 0; i < n; i++) begin
      drive_byte(msg_b[i], i == n - 1);
      if (i != n - 1 && maxgap > 0) idle_cycles($urandom_range(0, maxgap));
    end
  endtask

  task automatic pulse_ack();
    resp_ack_in = 1'b1;
    @(posedge clk);
    #1;
    resp_ack_in = 1'b0;
  endtask

  // Expected outcome from the message rules: >125 bytes overflows at byte 126,
  // a bad version byte or fewer than 4 bytes is a format error, else presented.
  task automatic verify(input int n, input int ackdly, input int eb, input int rb);
    logic [MSG_BITS-1:0] exp_bus;
    sample();
    if (n > 125) begin
      check("ovf_err_count", err_cnt - eb, 1);
      check("ovf_code", err_code_out, 2'b10);
      check("ovf_at_byte", err_at, 126);
      check("ovf_no_req", req_rise - rb, 0);
      check("ovf_bus_clear", auth_msg_resp_out, '0);
    end else if (msg_b[0] != 8'h01 || n < 4) begin
      check("fmt_err_pulse", err_out, 1'b1);
      check("fmt_err_count", err_cnt - eb, 1);
      check("fmt_code", err_code_out, 2'b11);
      check("fmt_at_byte", err_at, n);
      check("fmt_no_req", resp_req_out, 1'b0);
      check("fmt_bus_clear", auth_msg_resp_out, '0);
    end else begin
      exp_bus = '0;
      for (int i = 0; i < n; i++) exp_bus[8*i +: 8] = msg_b[i];
      check("pres_req", resp_req_out, 1'b1);
      check("pres_bus", auth_msg_resp_out, exp_bus);
      check("pres_len", msg_len_out, n);
      check("pres_ready_low", byte_ready_out, 1'b0);
      check("pres_no_err", err_cnt - eb, 0);
      idle_cycles(ackdly);
      check("pres_held_bus", auth_msg_resp_out, exp_bus);
      check("pres_held_req", resp_req_out, 1'b1);
      pulse_ack();
      sample();
      check("ack_req_drop", resp_req_out, 1'b0);
      check("ack_bus_clear", auth_msg_resp_out, '0);
      check("ack_len_clear", msg_len_out, 7'd0);
      check("ack_ready", byte_ready_out, 1'b1);
      check("ack_one_req", req_rise - rb, 1);
    end
  endtask

  task automatic run_msg(input int n, input int maxgap, input int ackdly);
    int eb, rb;
    eb = err_cnt;
    rb = req_rise;
    send_msg(n, maxgap);
    verify(n, ackdly, eb, rb);
  endtask

  task automatic fill(input int n, input logic [7:0] b0);
    msg_b[0] = b0;
    for (int i = 1; i < n; i++) msg_b[i] = 8'($urandom);
  endtask

  initial begin
    int eb, rb, n, k;
    reset = 1'b0;
    byte_valid_in = 1'b0;
    byte_data_in = 8'h00;
    byte_last_in = 1'b0;
    resp_ack_in = 1'b0;
    #1;
    check("rst_ready", byte_ready_out, 1'b0);
    check("rst_req", resp_req_out, 1'b0);
    check("rst_bus", auth_msg_resp_out, '0);
    check("rst_len", msg_len_out, 7'd0);
    check("rst_err", err_out, 1'b0);
    check("rst_code", err_code_out, 2'b00);
    idle_cycles(3);
    reset = 1'b1;
    sample();
    check("post_rst_ready", byte_ready_out, 1'b1);

    // Basic 4-byte message, ack three cycles later.
    msg_b[0] = 8'h01; msg_b[1] = 8'h02; msg_b[2] = 8'hAA; msg_b[3] = 8'h55;
    eb = err_cnt; rb = req_rise;
    send_msg(4, 0);
    sample();
    check("t1_req", resp_req_out, 1'b1);
    check("t1_bus_low", auth_msg_resp_out[31:0], 32'h55AA0201);
    check("t1_len", msg_len_out, 7'd4);
    idle_cycles(2);
    pulse_ack();
    sample();
    check("t1_req_drop", resp_req_out, 1'b0);
    check("t1_bus_clear", auth_msg_resp_out, '0);

    // Maximum legal length, then one byte too many.
    fill(125, 8'h01); run_msg(125, 0, 1);
    fill(126, 8'h01); run_msg(126, 0, 1);

    // Format errors: wrong version, too short.
    fill(6, 8'h02); run_msg(6, 1, 0);
    fill(3, 8'h01); run_msg(3, 0, 0);

    // Timeout after two bytes, checked to the exact cycle.
    eb = err_cnt;
    bytes_acc = 0;
    drive_byte(8'h01, 1'b0);
    drive_byte(8'h02, 1'b0);
    idle_cycles(TO_CYC - 1);
    sample();
    check("to_not_early", err_out, 1'b0);
    sample();
    check("to_pulse", err_out, 1'b1);
    check("to_code", err_code_out, 2'b01);
    sample();
    check("to_pulse_width", err_out, 1'b0);
    check("to_err_count", err_cnt - eb, 1);
    fill(9, 8'h01); run_msg(9, 2, 2);

    // Accept coinciding with timeout expiry: accept wins.
    eb = err_cnt; rb = req_rise;
    msg_b[0] = 8'h01; msg_b[1] = 8'h07; msg_b[2] = 8'h08; msg_b[3] = 8'h09;
    bytes_acc = 0;
    drive_byte(msg_b[0], 1'b0);
    drive_byte(msg_b[1], 1'b0);
    idle_cycles(TO_CYC - 1);
    drive_byte(msg_b[2], 1'b0);
    drive_byte(msg_b[3], 1'b1);
    verify(4, 0, eb, rb);

    // Overflow followed by silence: DISCARD times out without a second error.
    eb = err_cnt;
    bytes_acc = 0;
    drive_byte(8'h01, 1'b0);
    for (int i = 1; i < 127; i++) drive_byte(8'(i), 1'b0);
    idle_cycles(TO_CYC + 5);
    check("disc_one_err", err_cnt - eb, 1);
    check("disc_code", err_code_out, 2'b10);
    fill(5, 8'h01); run_msg(5, 0, 0);

    // Byte held during PRESENT waits and becomes byte 0 of the next message.
    fill(4, 8'h01);
    send_msg(4, 0);
    sample();
    check("t5_req", resp_req_out, 1'b1);
    byte_valid_in = 1'b1; byte_data_in = 8'h01; byte_last_in = 1'b0;
    idle_cycles(3);
    sample();
    check("t5_ready_low", byte_ready_out, 1'b0);
    eb = err_cnt; rb = req_rise;
    pulse_ack();
    byte_valid_in = 1'b1;
    sample();
    check("t5_ready_after_ack", byte_ready_out, 1'b1);
    check("t5_bus_clear", auth_msg_resp_out, '0);
    msg_b[0] = 8'h01; msg_b[1] = 8'h3C; msg_b[2] = 8'hC3; msg_b[3] = 8'h99;
    bytes_acc = 0;
    drive_byte(msg_b[0], 1'b0);
    drive_byte(msg_b[1], 1'b0);
    drive_byte(msg_b[2], 1'b0);
    drive_byte(msg_b[3], 1'b1);
    verify(4, 1, eb, rb);

    // Reset during COLLECT (err_code is nonzero beforehand).
    fill(3, 8'h02); run_msg(3, 0, 0);
    eb = err_cnt;
    drive_byte(8'h01, 1'b0);
    drive_byte(8'h11, 1'b0);
    drive_byte(8'h22, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("rc_ready", byte_ready_out, 1'b0);
    check("rc_bus", auth_msg_resp_out, '0);
    check("rc_code", err_code_out, 2'b00);
    check("rc_err", err_out, 1'b0);
    idle_cycles(2);
    reset = 1'b1;
    sample();
    check("rc_no_err", err_cnt - eb, 0);
    check("rc_ready_back", byte_ready_out, 1'b1);

    // Reset during PRESENT.
    fill(8, 8'h01);
    send_msg(8, 0);
    sample();
    check("rp_req_before", resp_req_out, 1'b1);
    eb = err_cnt;
    reset = 1'b0;
    #1;
    check("rp_req", resp_req_out, 1'b0);
    check("rp_bus", auth_msg_resp_out, '0);
    check("rp_len", msg_len_out, 7'd0);
    idle_cycles(2);
    reset = 1'b1;
    sample();
    check("rp_no_err", err_cnt - eb, 0);
    fill(4, 8'h01); run_msg(4, 0, 0);

    // Randomized messages against the rule-based expectation.
    for (int t = 0; t < 24; t++) begin
      k = $urandom_range(0, 9);
      if (k <= 5) begin n = $urandom_range(4, 125); fill(n, 8'h01); end
      else if (k == 6) begin n = $urandom_range(1, 20); fill(n, 8'($urandom_range(2, 255))); end
      else if (k == 7) begin n = $urandom_range(1, 3); fill(n, 8'h01); end
      else if (k == 8) begin n = $urandom_range(126, 130); fill(n, 8'h01); end
      else begin n = 125; fill(n, 8'h01); end
      run_msg(n, $urandom_range(0, 2), $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
